// File: rtl/accelerator_tensor_pkg.sv
// ---------------------------------------------------------------------------
// accelerator_tensor_pkg : shared types and helpers for the tensor feeder
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package accelerator_tensor_pkg;

  typedef enum logic [2:0] {
    STARTER = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    ENDER   = 3'd4
  } state_t;

  localparam logic [63:0] ZERO_DATA = 64'd0;
  localparam logic [63:0] ONE_DATA  = 64'd1;

  typedef struct packed {
    logic i_en;
    logic j_en;
    logic k_en;
  } strobe_t;

  // K marks every element, J the start of a row, I the start of a slice.
  function automatic strobe_t strobe_rule(input logic capture,
                                          input logic first_j,
                                          input logic first_i);
    strobe_t s;
    s.k_en = capture;
    s.j_en = capture & first_j;
    s.i_en = capture & first_i;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/accelerator_tensor_index_counter.sv
// ---------------------------------------------------------------------------
// accelerator_tensor_index_counter : i/j/k nested counter with linear offset
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accelerator_tensor_index_counter
  import accelerator_tensor_pkg::*;
#(
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 advance_i,
  input  logic [DATA_SIZE-1:0] size_i_i,
  input  logic [DATA_SIZE-1:0] size_j_i,
  input  logic [DATA_SIZE-1:0] size_k_i,
  output logic [DATA_SIZE-1:0] n_o,
  output logic                 first_j_o,
  output logic                 first_i_o,
  output logic                 last_o
);

  localparam logic [DATA_SIZE-1:0] ZERO = DATA_SIZE'(ZERO_DATA);
  localparam logic [DATA_SIZE-1:0] ONE  = DATA_SIZE'(ONE_DATA);

  logic [DATA_SIZE-1:0] i_q, i_d;
  logic [DATA_SIZE-1:0] j_q, j_d;
  logic [DATA_SIZE-1:0] k_q, k_d;
  logic [DATA_SIZE-1:0] n_q, n_d;
  logic                 i_last, j_last, k_last;

  assign i_last = (i_q == size_i_i - ONE);
  assign j_last = (j_q == size_j_i - ONE);
  assign k_last = (k_q == size_k_i - ONE);

  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    n_d = n_q;
    if (clear_i) begin
      i_d = ZERO;
      j_d = ZERO;
      k_d = ZERO;
      n_d = ZERO;
    end else if (advance_i) begin
      // n tracks (i*SJ + j)*SK + k incrementally, so no multiplier is needed.
      n_d = n_q + ONE;
      if (k_last) begin
        k_d = ZERO;
        if (j_last) begin
          j_d = ZERO;
          i_d = i_q + ONE;
        end else begin
          j_d = j_q + ONE;
        end
      end else begin
        k_d = k_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      i_q <= ZERO;
      j_q <= ZERO;
      k_q <= ZERO;
      n_q <= ZERO;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
      n_q <= n_d;
    end
  end

  assign n_o       = n_q;
  assign first_j_o = (k_q == ZERO);
  assign first_i_o = (k_q == ZERO) && (j_q == ZERO);
  assign last_o    = i_last && j_last && k_last;

endmodule

`default_nettype wire

// File: rtl/accelerator_tensor_float_feeder.sv
// ---------------------------------------------------------------------------
// accelerator_tensor_float_feeder : walks A/B tensors in memory, feeds pairs
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accelerator_tensor_float_feeder
  import accelerator_tensor_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] SIZE_K_IN,
  input  logic [DATA_SIZE-1:0] BASE_A_IN,
  input  logic [DATA_SIZE-1:0] BASE_B_IN,
  output logic                 RD_ENABLE,
  output logic [DATA_SIZE-1:0] ADDR_A_OUT,
  output logic [DATA_SIZE-1:0] ADDR_B_OUT,
  input  logic [DATA_SIZE-1:0] RD_DATA_A_IN,
  input  logic [DATA_SIZE-1:0] RD_DATA_B_IN,
  input  logic                 NEXT_IN,
  output logic [DATA_SIZE-1:0] DATA_A_OUT,
  output logic [DATA_SIZE-1:0] DATA_B_OUT,
  output logic                 DATA_OUT_I_ENABLE,
  output logic                 DATA_OUT_J_ENABLE,
  output logic                 DATA_OUT_K_ENABLE
);

  localparam logic [DATA_SIZE-1:0] ZERO = DATA_SIZE'(ZERO_DATA);

  // The control field width only has to hold the 3-bit state code.
  if (CONTROL_SIZE < 3) begin : g_control_size_narrow
  end

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] size_i_q, size_j_q, size_k_q;
  logic [DATA_SIZE-1:0] base_a_q, base_b_q;
  logic [DATA_SIZE-1:0] data_a_q, data_b_q;
  logic [DATA_SIZE-1:0] n_cnt;
  logic                 latch, advance, capture;
  logic                 first_j, first_i, last_elem;
  logic                 any_size_zero;
  strobe_t              strobe;

  accelerator_tensor_index_counter #(
    .DATA_SIZE (DATA_SIZE)
  ) u_index_counter (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clear_i   (latch),
    .advance_i (advance),
    .size_i_i  (size_i_q),
    .size_j_i  (size_j_q),
    .size_k_i  (size_k_q),
    .n_o       (n_cnt),
    .first_j_o (first_j),
    .first_i_o (first_i),
    .last_o    (last_elem)
  );

  assign any_size_zero = (SIZE_I_IN == ZERO) || (SIZE_J_IN == ZERO) ||
                         (SIZE_K_IN == ZERO);

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    RD_ENABLE = 1'b0;
    READY     = 1'b0;
    unique case (state_q)
      STARTER: begin
        if (START) begin
          latch   = 1'b1;
          state_d = any_size_zero ? ENDER : FETCH;
        end
      end
      FETCH: begin
        RD_ENABLE = 1'b1;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (NEXT_IN) begin
          if (last_elem) begin
            state_d = ENDER;
          end else begin
            advance = 1'b1;
            state_d = FETCH;
          end
        end
      end
      ENDER: begin
        READY   = 1'b1;
        state_d = STARTER;
      end
      default: state_d = STARTER;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= STARTER;
      size_i_q <= ZERO;
      size_j_q <= ZERO;
      size_k_q <= ZERO;
      base_a_q <= ZERO;
      base_b_q <= ZERO;
      data_a_q <= ZERO;
      data_b_q <= ZERO;
    end else begin
      state_q <= state_d;
      if (latch) begin
        size_i_q <= SIZE_I_IN;
        size_j_q <= SIZE_J_IN;
        size_k_q <= SIZE_K_IN;
        base_a_q <= BASE_A_IN;
        base_b_q <= BASE_B_IN;
      end
      if (capture) begin
        data_a_q <= RD_DATA_A_IN;
        data_b_q <= RD_DATA_B_IN;
      end
    end
  end

  // Address wrap past 2^DATA_SIZE is intentional and silent.
  assign ADDR_A_OUT = base_a_q + n_cnt;
  assign ADDR_B_OUT = base_b_q + n_cnt;
  assign DATA_A_OUT = data_a_q;
  assign DATA_B_OUT = data_b_q;

  assign strobe            = strobe_rule(capture, first_j, first_i);
  assign DATA_OUT_I_ENABLE = strobe.i_en;
  assign DATA_OUT_J_ENABLE = strobe.j_en;
  assign DATA_OUT_K_ENABLE = strobe.k_en;

endmodule

`default_nettype wire

// File: tb/tb_accelerator_tensor_float_feeder.sv
// ---------------------------------------------------------------------------
// tb_accelerator_tensor_float_feeder : directed + randomized walks vs model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_accelerator_tensor_float_feeder;

  localparam int DW = 64;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          READY;
  logic [DW-1:0] SIZE_I_IN = '0, SIZE_J_IN = '0, SIZE_K_IN = '0;
  logic [DW-1:0] BASE_A_IN = '0, BASE_B_IN = '0;
  logic          RD_ENABLE;
  logic [DW-1:0] ADDR_A_OUT, ADDR_B_OUT;
  logic [DW-1:0] RD_DATA_A_IN = '0, RD_DATA_B_IN = '0;
  logic          NEXT_IN = 1'b0;
  logic [DW-1:0] DATA_A_OUT, DATA_B_OUT;
  logic          I_EN, J_EN, K_EN;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] off_a = 64'd1;
  logic [DW-1:0] off_b = 64'd2;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    stb;
  } exp_t;

  accelerator_tensor_float_feeder #(
    .DATA_SIZE    (DW),
    .CONTROL_SIZE (4)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .START             (START),
    .READY             (READY),
    .SIZE_I_IN         (SIZE_I_IN),
    .SIZE_J_IN         (SIZE_J_IN),
    .SIZE_K_IN         (SIZE_K_IN),
    .BASE_A_IN         (BASE_A_IN),
    .BASE_B_IN         (BASE_B_IN),
    .RD_ENABLE         (RD_ENABLE),
    .ADDR_A_OUT        (ADDR_A_OUT),
    .ADDR_B_OUT        (ADDR_B_OUT),
    .RD_DATA_A_IN      (RD_DATA_A_IN),
    .RD_DATA_B_IN      (RD_DATA_B_IN),
    .NEXT_IN           (NEXT_IN),
    .DATA_A_OUT        (DATA_A_OUT),
    .DATA_B_OUT        (DATA_B_OUT),
    .DATA_OUT_I_ENABLE (I_EN),
    .DATA_OUT_J_ENABLE (J_EN),
    .DATA_OUT_K_ENABLE (K_EN)
  );

  always #5 CLK = ~CLK;

  // Synchronous memory: contents are address plus a per-tensor offset.
  always @(posedge CLK) begin
    if (RD_ENABLE) begin
      RD_DATA_A_IN <= ADDR_A_OUT + off_a;
      RD_DATA_B_IN <= ADDR_B_OUT + off_b;
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(READY), 64'd0);
    chk({tag, "_rd"}, 64'(RD_ENABLE), 64'd0);
    chk({tag, "_stb"}, 64'({I_EN, J_EN, K_EN}), 64'd0);
    chk({tag, "_addr_a"}, ADDR_A_OUT, 64'd0);
    chk({tag, "_addr_b"}, ADDR_B_OUT, 64'd0);
    chk({tag, "_data_a"}, DATA_A_OUT, 64'd0);
    chk({tag, "_data_b"}, DATA_B_OUT, 64'd0);
  endtask

  // One tensor walk. tied: NEXT_IN held high. Otherwise NEXT_IN pulses a
  // delay into each HOLD (random up to max_dly, or fixed at max_dly).
  task automatic run_walk(input int si, input int sj, input int sk,
                          input logic [DW-1:0] ba, input logic [DW-1:0] bb,
                          input bit tied, input bit rand_dly, input int max_dly,
                          input bit restart, input int abort_at);
    exp_t q[$];
    int   dly[$];
    exp_t e;
    logic [DW-1:0] n;
    int exp_ready, rd_idx, stb_idx, cur, pend, hold_start, hold_el;
    bit upd, has_cur, done;

    n = '0;
    for (int i = 0; i < si; i++)
      for (int j = 0; j < sj; j++)
        for (int k = 0; k < sk; k++) begin
          e.a   = ba + n;
          e.b   = bb + n;
          e.stb = {(k == 0 && j == 0), (k == 0), 1'b1};
          q.push_back(e);
          dly.push_back(tied ? 0 : (rand_dly ? int'($urandom_range(0, max_dly)) : max_dly));
          n = n + 64'd1;
        end
    exp_ready = 1;
    foreach (dly[x]) exp_ready += 3 + dly[x];

    rd_idx = 0; stb_idx = 0; cur = 0; pend = 0; hold_start = -1; hold_el = 0;
    upd = 0; has_cur = 0; done = 0;

    @(negedge CLK);
    chk("idle_ready", 64'(READY), 64'd0);
    chk("idle_rd", 64'(RD_ENABLE), 64'd0);
    SIZE_I_IN = 64'(si); SIZE_J_IN = 64'(sj); SIZE_K_IN = 64'(sk);
    BASE_A_IN = ba; BASE_B_IN = bb;
    START = 1'b1;
    NEXT_IN = tied;

    for (int t = 1; t <= 800 && !done; t++) begin
      @(negedge CLK);
      START = 1'b0;
      NEXT_IN = tied;
      if (RST) begin
        chk_all_zero("after_abort");
        RST = 1'b0;
        for (int w = 0; w < 4; w++) begin
          @(negedge CLK);
          chk("abort_no_ready", 64'(READY), 64'd0);
          chk("abort_no_rd", 64'(RD_ENABLE), 64'd0);
        end
        done = 1;
      end else begin
        if (upd) begin cur = pend; has_cur = 1; upd = 0; end
        if (has_cur) begin
          chk("data_a", DATA_A_OUT, q[cur].a + off_a);
          chk("data_b", DATA_B_OUT, q[cur].b + off_b);
        end
        if (RD_ENABLE) begin
          if (rd_idx < q.size()) begin
            chk("addr_a", ADDR_A_OUT, q[rd_idx].a);
            chk("addr_b", ADDR_B_OUT, q[rd_idx].b);
          end else begin
            chk("extra_rd", 64'(RD_ENABLE), 64'd0);
          end
          rd_idx++;
        end
        if (I_EN || J_EN || K_EN) begin
          if (stb_idx < q.size()) begin
            chk("strobes", 64'({I_EN, J_EN, K_EN}), 64'(q[stb_idx].stb));
            if (stb_idx == 0) chk("first_stb_cycle", 64'(t), 64'd2);
            pend = stb_idx; upd = 1;
            hold_start = t + 1; hold_el = stb_idx;
            if (stb_idx == abort_at) RST = 1'b1;
          end else begin
            chk("extra_stb", 64'({I_EN, J_EN, K_EN}), 64'd0);
          end
          stb_idx++;
        end
        if (!tied && hold_start >= 0 && t == hold_start + dly[hold_el]) begin
          NEXT_IN = 1'b1;
          hold_start = -1;
        end
        if (restart && t == 3) begin
          START = 1'b1;
          SIZE_I_IN = 64'd5; SIZE_J_IN = 64'd5; SIZE_K_IN = 64'd5;
          BASE_A_IN = 64'h9000; BASE_B_IN = 64'hA000;
        end
        if (READY) begin
          chk("ready_cycle", 64'(t), 64'(exp_ready));
          chk("read_count", 64'(rd_idx), 64'(q.size()));
          chk("strobe_count", 64'(stb_idx), 64'(q.size()));
          done = 1;
        end
      end
    end
    chk("walk_completed", 64'(done), 64'd1);
    START = 1'b0;
    NEXT_IN = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b0;

    // 2x2x2, NEXT tied high
    off_a = 64'd1; off_b = 64'd2;
    run_walk(2, 2, 2, 64'h100, 64'h200, 1'b1, 1'b0, 0, 1'b0, -1);

    // 1x1x3, NEXT five cycles into each HOLD
    run_walk(1, 1, 3, 64'h340, 64'h780, 1'b0, 1'b0, 5, 1'b0, -1);

    // zero extent in j: no reads, READY straight away
    run_walk(3, 0, 2, 64'h10, 64'h20, 1'b1, 1'b0, 0, 1'b0, -1);

    // START re-pulsed during HOLD is ignored
    run_walk(2, 1, 3, 64'h400, 64'h800, 1'b1, 1'b0, 0, 1'b1, -1);

    // reset during CAPTURE of the third element, then a fresh walk
    run_walk(2, 2, 2, 64'h100, 64'h200, 1'b1, 1'b0, 0, 1'b0, 2);
    run_walk(2, 2, 2, 64'h100, 64'h200, 1'b1, 1'b0, 0, 1'b0, -1);

    // address wrap at the top of the 64-bit space
    run_walk(1, 1, 4, 64'hFFFF_FFFF_FFFF_FFFE, 64'h55, 1'b1, 1'b0, 0, 1'b0, -1);

    // randomized walks
    for (int r = 0; r < 5; r++) begin
      off_a = {$urandom, $urandom};
      off_b = {$urandom, $urandom};
      run_walk(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
               int'($urandom_range(1, 3)), {$urandom, $urandom},
               {$urandom, $urandom}, 1'b0, 1'b1, 4, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
